// File: rtl/alu_control.sv
// ALU control decoder: maps main-control ALUop plus the R-type function field
// to a 3-bit ALU operation, registered with one cycle of latency.
module alu_control #(
   parameter bit FULL_DECODE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [1:0] ALUop,
   input  logic [5:0] Func,
   output logic [2:0] ALUoper,
   output logic       out_valid,
   output logic       illegal
);

   logic [2:0] dec_oper;
   logic       dec_illegal;
   logic       rtype_prefix_ok;

   assign rtype_prefix_ok = !FULL_DECODE || (Func[5:4] == 2'b10);

   always_comb begin
      dec_oper    = 3'b010;
      dec_illegal = 1'b0;
      if (!ALUop[1]) begin
         dec_oper = ALUop[0] ? 3'b110 : 3'b010;
      end else begin
         unique case (Func[3:0])
            4'b0000: dec_oper = 3'b010;
            4'b0010: dec_oper = 3'b110;
            4'b0100: dec_oper = 3'b000;
            4'b0101: dec_oper = 3'b001;
            4'b0110: dec_oper = 3'b011;
            4'b0111: dec_oper = 3'b100;
            4'b1010: dec_oper = 3'b111;
            4'b1011: dec_oper = 3'b101;
            default: dec_illegal = 1'b1;
         endcase
         // Unknown codes fall back to add so a downstream ALU still sees a benign op.
         if (!rtype_prefix_ok || dec_illegal) begin
            dec_oper    = 3'b010;
            dec_illegal = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALUoper   <= 3'b000;
         out_valid <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            ALUoper <= dec_oper;
            illegal <= dec_illegal;
         end
      end
   end

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: both decode widths run side by side on
// the same stimulus and are compared against a table-driven reference model.
module tb_alu_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [1:0] ALUop;
   logic [5:0] Func;
   logic [2:0] oper0, oper1;
   logic       v0, v1, ill0, ill1;

   int errors = 0;
   int checks = 0;

   logic [2:0] e_oper [2];
   logic       e_v    [2];
   logic       e_ill  [2];
   int         rmap [int];

   always #5 clk = ~clk;

   alu_control #(.FULL_DECODE(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUop(ALUop), .Func(Func),
      .ALUoper(oper0), .out_valid(v0), .illegal(ill0)
   );

   alu_control #(.FULL_DECODE(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUop(ALUop), .Func(Func),
      .ALUoper(oper1), .out_valid(v1), .illegal(ill1)
   );

   // Returns {illegal, oper} from the function-code table.
   function automatic logic [3:0] model(input bit full, input logic [1:0] op, input logic [5:0] f);
      int key;
      key = int'(f[3:0]);
      if (op == 2'b00) return 4'b0_010;
      if (op == 2'b01) return 4'b0_110;
      if (rmap.exists(key) && (!full || f[5:4] == 2'b10))
         return {1'b0, 3'(rmap[key])};
      return 4'b1_010;
   endfunction

   function automatic logic [4:0] exp_vec(input int d);
      return {e_oper[d], e_v[d], e_ill[d]};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         e_oper[d] = 3'b000; e_v[d] = 1'b0; e_ill[d] = 1'b0;
      end
   endtask

   // Called at a falling edge; returns at the next falling edge with the model advanced.
   task automatic step(input logic v, input logic [1:0] op, input logic [5:0] f);
      in_valid = v; ALUop = op; Func = f;
      for (int d = 0; d < 2; d++) begin
         e_v[d] = v;
         if (v) {e_ill[d], e_oper[d]} = model(d == 1, op, f);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; ALUop = 2'b00; Func = 6'd0;
      model_reset();
      #12;
      checks++;
      if ({oper0, v0, ill0} !== 5'b000_0_0) begin
         errors++; $display("FAIL reset_dut0 got=%b exp=00000", {oper0, v0, ill0});
      end
      checks++;
      if ({oper1, v1, ill1} !== 5'b000_0_0) begin
         errors++; $display("FAIL reset_dut1 got=%b exp=00000", {oper1, v1, ill1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 2'b10, 6'b001111);
      checks++;
      if ({oper0, v0, ill0} !== exp_vec(0)) begin
         errors++; $display("FAIL idle_after_reset got=%b exp=%b", {oper0, v0, ill0}, exp_vec(0));
      end
   endtask

   task automatic test_basic();
      step(1'b1, 2'b00, 6'b000000);
      checks++;
      if ({oper0, v0, ill0} !== 5'b010_1_0) begin
         errors++; $display("FAIL load_add got=%b exp=01010", {oper0, v0, ill0});
      end
      step(1'b1, 2'b01, 6'b101010);
      checks++;
      if ({oper0, v0, ill0} !== 5'b110_1_0) begin
         errors++; $display("FAIL branch_sub got=%b exp=11010", {oper0, v0, ill0});
      end
      checks++;
      if ({oper1, v1, ill1} !== 5'b110_1_0) begin
         errors++; $display("FAIL branch_sub_full got=%b exp=11010", {oper1, v1, ill1});
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] funcs [5] = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001010};
      logic [2:0] opers [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 2'b11, funcs[i]);
         checks++;
         if ({oper0, v0, ill0} !== {opers[i], 2'b10}) begin
            errors++; $display("FAIL rtype_seq[%0d] got=%b exp=%b", i, {oper0, v0, ill0}, {opers[i], 2'b10});
         end
         checks++;
         if ({oper1, v1, ill1} !== exp_vec(1)) begin
            errors++; $display("FAIL rtype_seq_full[%0d] got=%b exp=%b", i, {oper1, v1, ill1}, exp_vec(1));
         end
      end
   endtask

   task automatic test_illegal();
      step(1'b1, 2'b10, 6'b001111);
      checks++;
      if ({oper0, v0, ill0} !== 5'b010_1_1) begin
         errors++; $display("FAIL illegal_func got=%b exp=01011", {oper0, v0, ill0});
      end
      step(1'b1, 2'b10, 6'b000000);
      checks++;
      if ({oper1, v1, ill1} !== 5'b010_1_1) begin
         errors++; $display("FAIL full_prefix got=%b exp=01011", {oper1, v1, ill1});
      end
      checks++;
      if ({oper0, v0, ill0} !== 5'b010_1_0) begin
         errors++; $display("FAIL partial_prefix got=%b exp=01010", {oper0, v0, ill0});
      end
      step(1'b1, 2'b10, 6'b100111);
      checks++;
      if ({oper1, v1, ill1} !== 5'b100_1_0) begin
         errors++; $display("FAIL full_nor got=%b exp=10010", {oper1, v1, ill1});
      end
   endtask

   task automatic test_hold();
      step(1'b1, 2'b10, 6'b011011);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 2'($urandom), 6'($urandom));
         checks++;
         if ({oper0, v0, ill0} !== 5'b101_0_0) begin
            errors++; $display("FAIL hold_dut0[%0d] got=%b exp=10100", i, {oper0, v0, ill0});
         end
         checks++;
         if ({oper1, v1, ill1} !== 5'b010_0_1) begin
            errors++; $display("FAIL hold_dut1[%0d] got=%b exp=01001", i, {oper1, v1, ill1});
         end
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, 2'b10, 6'b101010);
      checks++;
      if ({oper0, v0, ill0} !== 5'b111_1_0) begin
         errors++; $display("FAIL pre_reset got=%b exp=11110", {oper0, v0, ill0});
      end
      in_valid = 1'b1; ALUop = 2'b10; Func = 6'b100110;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({oper0, v0, ill0, oper1, v1, ill1} !== 10'd0) begin
         errors++; $display("FAIL async_reset got=%b exp=0000000000", {oper0, v0, ill0, oper1, v1, ill1});
      end
      @(posedge clk); #1;
      checks++;
      if ({oper0, v0, ill0} !== 5'b000_0_0) begin
         errors++; $display("FAIL reset_discard got=%b exp=00000", {oper0, v0, ill0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b1, 2'b01, 6'b000000);
      checks++;
      if ({oper0, v0, ill0} !== 5'b110_1_0) begin
         errors++; $display("FAIL first_after_reset got=%b exp=11010", {oper0, v0, ill0});
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) != 0, 2'($urandom), 6'($urandom));
         checks++;
         if ({oper0, v0, ill0} !== exp_vec(0)) begin
            errors++; $display("FAIL random_dut0[%0d] got=%b exp=%b", i, {oper0, v0, ill0}, exp_vec(0));
         end
         checks++;
         if ({oper1, v1, ill1} !== exp_vec(1)) begin
            errors++; $display("FAIL random_dut1[%0d] got=%b exp=%b", i, {oper1, v1, ill1}, exp_vec(1));
         end
      end
   endtask

   initial begin
      rmap[4'b0000] = 3'b010;
      rmap[4'b0010] = 3'b110;
      rmap[4'b0100] = 3'b000;
      rmap[4'b0101] = 3'b001;
      rmap[4'b0110] = 3'b011;
      rmap[4'b0111] = 3'b100;
      rmap[4'b1010] = 3'b111;
      rmap[4'b1011] = 3'b101;
      test_reset();
      test_basic();
      test_back_to_back();
      test_illegal();
      test_hold();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: ALUcontrol

Interface
REQ-001 The block SHALL have parameter FULL_DECODE, default 0; 0 decodes Func[3:0] only, 1 additionally requires Func[5:4]=2'b10 for a legal R-type code.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: ALUop and Func are valid this cycle.
REQ-005 The block SHALL have port ALUop, input, 2 bits: main-control ALU class (00 load/store add, 01 branch subtract, 1x R-type).
REQ-006 The block SHALL have port Func, input, 6 bits: instruction function field.
REQ-007 The block SHALL have port ALUoper, output, 3 bits: registered ALU operation code.
REQ-008 The block SHALL have port out_valid, output, 1 bit: registered copy of in_valid.
REQ-009 The block SHALL have port illegal, output, 1 bit: registered flag for an undecodable R-type Func.

Function
REQ-010 Decode SHALL be combinational; ALUoper, out_valid and illegal SHALL be registered on the rising edge of clk, giving 1-cycle latency.
REQ-011 When ALUop=00, the decoded operation SHALL be 010 (add), with illegal=0; Func is ignored.
REQ-012 When ALUop=01, the decoded operation SHALL be 110 (subtract), with illegal=0; Func is ignored.
REQ-013 When ALUop[1]=1, the R-type decode SHALL apply regardless of ALUop[0], so 10 and 11 behave identically.
REQ-014 R-type decode on Func[3:0] SHALL be:
- 0000 -> 010 (add)
- 0010 -> 110 (sub)
- 0100 -> 000 (and)
- 0101 -> 001 (or)
- 0110 -> 011 (xor)
- 0111 -> 100 (nor)
- 1010 -> 111 (slt)
- 1011 -> 101 (sltu)
REQ-015 For any other R-type Func[3:0], and when FULL_DECODE=1 with Func[5:4]!=2'b10, the decoded operation SHALL be 010 and illegal SHALL be 1.
REQ-016 When in_valid=0, the registers SHALL hold their previous ALUoper and illegal values and out_valid SHALL be 0 on the next edge.
REQ-017 When in_valid=1, all three registers SHALL update every cycle; back-to-back inputs SHALL be accepted without stall.
REQ-018 Outputs SHALL NOT depend combinationally on the inputs.
REQ-019 ALUop and Func are treated as 2-state inputs; X or Z inputs have no defined behaviour.

Reset
REQ-020 When rst_n=0, the block SHALL immediately drive ALUoper=000, out_valid=0 and illegal=0, independent of clk.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-022 After rst_n is released, the first rising edge with in_valid=1 SHALL load a new result.

Verification
REQ-023 Reset, then in_valid=1 with ALUop=00 and Func=000000 -> after one edge: ALUoper=010, out_valid=1, illegal=0.
REQ-024 ALUop=01 with Func=101010 -> ALUoper=110, illegal=0.
REQ-025 With ALUop=11 (ALUop[1]=1), apply Func=000000, 000010, 000100, 000101, 001010 on consecutive cycles -> ALUoper=010, 110, 000, 001, 111 on consecutive cycles, illegal=0 throughout.
REQ-026 ALUop=10 with Func=001111 -> ALUoper=010, illegal=1; with FULL_DECODE=1, Func=000000 -> ALUoper=010, illegal=1.
REQ-027 After a valid result, drop in_valid for 2 cycles -> out_valid=0 and ALUoper/illegal unchanged.
REQ-028 Assert rst_n=0 between clock edges -> outputs go to 000/0/0 before the next edge.
